// File: rtl/keyboard_chatta_can_multi.sv
// N-channel chattering canceller: prescaled sample tick, STABLE-tick acceptance, edge pulses.
// Define KEYBOARD_CHATTA_INSYNC_EN to add a 2-FF input synchronizer for asynchronous pins.
module keyboard_chatta_can_multi #(
    parameter int unsigned  N         = 1,
    parameter int unsigned  DIV       = 1250,
    parameter int unsigned  STABLE    = 4,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         iCLOCK,
    input  logic         iRESET_SYNC,
    input  logic [N-1:0] iDATA,
    output logic [N-1:0] oDATA,
    output logic [N-1:0] oRISE,
    output logic [N-1:0] oFALL,
    output logic         oCHANGE,
    output logic         oTICK
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned ScW  = $clog2(STABLE + 1);
    localparam logic [CntW-1:0] LastDiv    = CntW'(DIV - 1);
    localparam logic [ScW-1:0]  LastStable = ScW'(STABLE - 1);

    logic [N-1:0] sampleIn;

`ifdef KEYBOARD_CHATTA_INSYNC_EN
    logic [N-1:0] syncMeta;
    logic [N-1:0] syncOut;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            syncMeta <= RESET_VAL;
            syncOut  <= RESET_VAL;
        end else begin
            syncMeta <= iDATA;
            syncOut  <= syncMeta;
        end
    end

    assign sampleIn = syncOut;
`else
    assign sampleIn = iDATA;
`endif

    logic [CntW-1:0] prescCnt;
    logic            sampleTick;

    assign sampleTick = (prescCnt == LastDiv);

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            prescCnt <= '0;
        end else if (sampleTick) begin
            prescCnt <= '0;
        end else begin
            prescCnt <= prescCnt + CntW'(1);
        end
    end

    logic [ScW-1:0] stableCnt     [N];
    logic [ScW-1:0] stableCntNext [N];
    logic [N-1:0]   dataNext;
    logic [N-1:0]   riseNext;
    logic [N-1:0]   fallNext;

    always_comb begin
        dataNext = oDATA;
        riseNext = '0;
        fallNext = '0;
        for (int i = 0; i < N; i++) begin
            stableCntNext[i] = stableCnt[i];
            if (sampleTick) begin
                if (sampleIn[i] == oDATA[i]) begin
                    stableCntNext[i] = '0;
                end else if (stableCnt[i] == LastStable) begin
                    // STABLE-th consecutive differing sample: accept the new level
                    dataNext[i]      = sampleIn[i];
                    riseNext[i]      = sampleIn[i];
                    fallNext[i]      = ~sampleIn[i];
                    stableCntNext[i] = '0;
                end else begin
                    stableCntNext[i] = stableCnt[i] + ScW'(1);
                end
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            oDATA   <= RESET_VAL;
            oRISE   <= '0;
            oFALL   <= '0;
            oCHANGE <= 1'b0;
            oTICK   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                stableCnt[i] <= '0;
            end
        end else begin
            oDATA   <= dataNext;
            oRISE   <= riseNext;
            oFALL   <= fallNext;
            oCHANGE <= |(riseNext | fallNext);
            oTICK   <= sampleTick;
            for (int i = 0; i < N; i++) begin
                stableCnt[i] <= stableCntNext[i];
            end
        end
    end

endmodule

// File: tb/tb_keyboard_chatta_can_multi.sv
// Bench for keyboard_chatta_can_multi: two instances (DIV=4/STABLE=3, DIV=1/STABLE=1) checked
// every cycle against a sample-history model, plus literal checks of the key scenarios.
module tb_keyboard_chatta_can_multi;

    localparam logic [1:0] RV1 = 2'b10;
`ifdef KEYBOARD_CHATTA_INSYNC_EN
    localparam int FollowLat = 3;
`else
    localparam int FollowLat = 1;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] d0, d1;
    logic [1:0] data0, rise0, fall0, data1, rise1, fall1;
    logic       chg0, tick0, chg1, tick1;

    keyboard_chatta_can_multi #(.N(2), .DIV(4), .STABLE(3), .RESET_VAL(2'b00)) dut0 (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iDATA(d0), .oDATA(data0), .oRISE(rise0),
        .oFALL(fall0), .oCHANGE(chg0), .oTICK(tick0)
    );

    keyboard_chatta_can_multi #(.N(2), .DIV(1), .STABLE(1), .RESET_VAL(RV1)) dut1 (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iDATA(d1), .oDATA(data1), .oRISE(rise1),
        .oFALL(fall1), .oCHANGE(chg1), .oTICK(tick1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nCmp = 0;
    int nErr = 0;
    int edgeCnt = 0;
    bit started = 1'b0;

    task automatic check(string name, logic [1:0] act, logic [1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a channel accepts when its last STABLE samples since the previous
    // acceptance (or reset) all differ from the current output level.
    int         divs[2]    = '{4, 1};
    int         stbs[2]    = '{3, 1};
    logic [1:0] rvs[2]     = '{2'b00, RV1};
    int         mEdge[2];
    logic [1:0] mOut[2], mRise[2], mFall[2], p1[2], p2[2];
    logic       mTick[2], mChg[2];
    logic [31:0] hist[2][2];
    int         hlen[2][2];

    task automatic modelStep(int k, logic rstIn, logic [1:0] din);
        logic [1:0]  s;
        logic [31:0] mask;
        mRise[k] = 2'b00;
        mFall[k] = 2'b00;
        mTick[k] = 1'b0;
        mChg[k]  = 1'b0;
        if (rstIn) begin
            mEdge[k] = 0;
            mOut[k]  = rvs[k];
            p1[k]    = rvs[k];
            p2[k]    = rvs[k];
            for (int c = 0; c < 2; c++) begin
                hlen[k][c] = 0;
                hist[k][c] = '0;
            end
            return;
        end
`ifdef KEYBOARD_CHATTA_INSYNC_EN
        s     = p2[k];
        p2[k] = p1[k];
        p1[k] = din;
`else
        s = din;
`endif
        mEdge[k]++;
        if (mEdge[k] % divs[k] == 0) begin
            mTick[k] = 1'b1;
            mask = (32'd1 << stbs[k]) - 32'd1;
            for (int c = 0; c < 2; c++) begin
                hist[k][c] = {hist[k][c][30:0], s[c]};
                hlen[k][c]++;
                if (hlen[k][c] >= stbs[k] &&
                    (hist[k][c] & mask) == (mOut[k][c] ? 32'd0 : mask)) begin
                    mOut[k][c]  = s[c];
                    mRise[k][c] = s[c];
                    mFall[k][c] = ~s[c];
                    hlen[k][c]  = 0;
                    hist[k][c]  = '0;
                end
            end
            mChg[k] = |(mRise[k] | mFall[k]);
        end
    endtask

    always @(posedge clk) begin
        modelStep(0, rst, d0);
        modelStep(1, rst, d1);
        if (rst) edgeCnt <= 0;
        else     edgeCnt <= edgeCnt + 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("m0_data", data0, mOut[0]);
            check("m0_rise", rise0, mRise[0]);
            check("m0_fall", fall0, mFall[0]);
            check("m0_chg_tick", {chg0, tick0}, {mChg[0], mTick[0]});
            check("m1_data", data1, mOut[1]);
            check("m1_rise", rise1, mRise[1]);
            check("m1_fall", fall1, mFall[1]);
            check("m1_chg_tick", {chg1, tick1}, {mChg[1], mTick[1]});
        end
    end

    task automatic goEdge(int t);
        while (edgeCnt < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] v;
        bit found;
        rst = 1'b1;
        d0  = 2'b01;
        d1  = RV1;
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        check("reset_data0", data0, 2'b00);
        check("reset_data1", data1, RV1);
        check("reset_pulses", rise0 | fall0 | rise1 | fall1, 2'b00);
        rst = 1'b0;

        // Reset release with 01 held: accepted on the third tick (edge 12)
        goEdge(11);
        check("t1_before", data0, 2'b00);
        check("t6_hold", data1, RV1);
        check("t4_tick_every", {1'b0, tick1}, 2'b01);
        goEdge(12);
        check("t1_data", data0, 2'b01);
        check("t1_rise", rise0, 2'b01);
        check("t1_chg_tick", {chg0, tick0}, 2'b11);
        goEdge(13);
        check("t1_rise_gone", {rise0[0], chg0}, 2'b00);
        check("t6_no_pulse", rise1 | fall1, 2'b00);

        // DIV=1 STABLE=1 follows its input
        d1 = 2'b01;
        repeat (FollowLat) @(posedge clk);
        #1;
        check("t4_follow", data1, 2'b01);

        // Both channels fall together
        d0 = 2'b11;
        repeat (30) @(posedge clk);
        #1;
        check("t3_set", data0, 2'b11);
        d0 = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #1;
            if (fall0 !== 2'b00) found = 1'b1;
        end
        check("t3_fall_both", fall0, 2'b11);
        check("t3_chg", {1'b0, chg0}, 2'b01);

        // Bounce: two ticks of 1 then back to 0; re-assert needs three fresh ticks
        pulseReset();
        d0 = 2'b01;
        goEdge(9);
        d0 = 2'b00;
        goEdge(13);
        check("t2_bounce", data0, 2'b00);
        d0 = 2'b01;
        goEdge(23);
        check("t2_not_yet", data0, 2'b00);
        goEdge(24);
        check("t2_accept", rise0, 2'b01);

        // Reset after two accepting ticks discards the partial count
        pulseReset();
        d0 = 2'b10;
        goEdge(9);
        pulseReset();
        check("t5_cleared", data0, 2'b00);
        goEdge(11);
        check("t5_not_yet", data0, 2'b00);
        goEdge(12);
        check("t5_accept", data0, 2'b10);

        // Randomized bouncing segments with occasional resets
        v = 2'b00;
        for (int seg = 0; seg < 120; seg++) begin
            v = 2'($urandom);
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) begin
                @(posedge clk);
                #1;
                rst = ($urandom % 300) == 0;
                d0  = v;
                if ($urandom % 6 == 0) d0[$urandom % 2] = ~v[0];
                if ($urandom % 3 == 0) d1 = 2'($urandom);
            end
        end
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
